load_hazard_unit: RTL

Parametrised load-use hazard detector for the pipeline's ID stage. It is the successor to the single-cycle load-use check. It tracks in-flight loads across a configurable load latency and excludes register 0 and unused source operands. It drives the PC/IF-ID hold (`Stall`) and the ID/EX bubble insert (`Bubble`) in the same cycle a hazard is seen, and optionally counts stall cycles for performance measurement.

---
 rtl/load_hazard_unit.sv | 120 ++++++++++++
 1 files changed

// File: rtl/load_hazard_unit.sv
// ============================================================================
// Module   : load_hazard_unit
// Purpose  : ID-stage load-use hazard detector with a LOAD_LAT-deep pending-
//            load tracker; drives Stall/Bubble. Optional stall counter is
//            enabled by defining HAZARD_STALL_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_hazard_unit #(
    parameter int REG_W    = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             MemRead_EX,
    input  logic [REG_W-1:0] Rt_EX,
    input  logic             Valid_ID,
    input  logic [REG_W-1:0] Rs_ID,
    input  logic [REG_W-1:0] Rt_ID,
    input  logic             UsesRt_ID,
    output logic             Stall,
    output logic             Bubble,
    output logic [CNT_W-1:0] StallCount
);

    localparam int c_CHAIN_N = (LOAD_LAT > 1) ? LOAD_LAT - 1 : 1;

    function automatic logic src_match(input logic [REG_W-1:0] src,
                                       input logic [REG_W-1:0] dst);
        return (src != '0) && (src == dst);
    endfunction

    logic w_ex_hit;
    logic w_chain_hit;
    logic w_hazard;

    always_comb begin
        w_ex_hit = MemRead_EX &&
                   (src_match(Rs_ID, Rt_EX) || (UsesRt_ID && src_match(Rt_ID, Rt_EX)));
    end

    generate
        if (LOAD_LAT > 1) begin : g_chain
            logic [c_CHAIN_N-1:0] vld_q;
            logic [c_CHAIN_N-1:0] vld_d;
            logic [REG_W-1:0]     dst_q [c_CHAIN_N];
            logic [REG_W-1:0]     dst_d [c_CHAIN_N];

            // The chain shifts every cycle, stall or not: loads past ID keep moving.
            always_comb begin
                vld_d[0] = MemRead_EX && (Rt_EX != '0);
                dst_d[0] = Rt_EX;
                for (int k = 1; k < c_CHAIN_N; k++) begin
                    vld_d[k] = vld_q[k-1];
                    dst_d[k] = dst_q[k-1];
                end
            end

            always_ff @(posedge Clk) begin
                if (Reset) begin
                    vld_q <= '0;
                    for (int k = 0; k < c_CHAIN_N; k++) begin
                        dst_q[k] <= '0;
                    end
                end else begin
                    vld_q <= vld_d;
                    dst_q <= dst_d;
                end
            end

            always_comb begin
                w_chain_hit = 1'b0;
                for (int k = 0; k < c_CHAIN_N; k++) begin
                    if (vld_q[k] && (src_match(Rs_ID, dst_q[k]) ||
                                     (UsesRt_ID && src_match(Rt_ID, dst_q[k])))) begin
                        w_chain_hit = 1'b1;
                    end
                end
            end
        end else begin : g_no_chain
            logic unused_clk;
            assign unused_clk  = Clk;
            assign w_chain_hit = 1'b0;
        end
    endgenerate

    assign w_hazard = Valid_ID && (w_ex_hit || w_chain_hit);
    assign Stall    = w_hazard || Reset;
    assign Bubble   = w_hazard || Reset;

`ifdef HAZARD_STALL_CNT_EN
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Saturates at all-ones rather than wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (Stall && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign StallCount = cnt_q;
`else
    assign StallCount = '0;
`endif

endmodule

`default_nettype wire
